// File: rtl/spiflash_mio.sv
// Read-only SPI flash slave (0x03/0x0B/0x3B/0x6B) serving bytes from a BRAM image.
// Define SPIFLASH_QUAD_EN to enable the 0x6B quad-output read; otherwise 0x6B is ignored.
module spiflash_mio #(
   parameter int ADDR_BYTES   = 3,
   parameter int DUMMY_CYCLES = 8,
   parameter int MEM_BYTES    = 8192
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   output logic [31:0] romcode_Addr_A,
   output logic        romcode_EN_A,
   output logic [3:0]  romcode_WEN_A,
   output logic [31:0] romcode_Din_A,
   input  logic [31:0] romcode_Dout_A,
   output logic        romcode_Clk_A,
   output logic        romcode_Rst_A,
   input  logic        csb,
   input  logic        spiclk,
   input  logic [3:0]  io_in,
   output logic [3:0]  io_out,
   output logic [3:0]  io_oe
);
   localparam int         AW         = $clog2(MEM_BYTES);
   localparam logic [7:0] ADDR_LAST  = 8'(8 * ADDR_BYTES - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
   typedef enum logic [1:0] {M_SINGLE, M_DUAL, M_QUAD} mode_t;

   state_t        r_state, w_state_nxt, w_cmd_state;
   mode_t         r_mode, w_cmd_mode;
   logic          r_dummy;
   logic          r_csb_s1, r_csb_s2, r_clk_s1, r_clk_s2, r_clk_d, r_io_s1, r_io_s2;
   logic [1:0]    r_live;
   logic          r_armed;
   logic [6:0]    r_cmd_sr;
   logic [AW-2:0] r_addr_sr;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_cnt;
   logic [2:0]    r_gcnt;
   logic [7:0]    r_sh;
   logic [3:0]    r_out;
   logic [31:0]   r_word, r_baddr;
   logic          r_en, r_en_d;
   logic          w_rise, w_fall;
   logic [7:0]    w_cmd_byte, w_byte;
   logic [AW-1:0] w_addr_rx, w_addr_inc;
   logic [31:0]   w_word;
   logic          w_unused_io;

   function automatic logic [3:0] f_grp(input mode_t m, input logic [7:0] b);
      case (m)
         M_DUAL:  return {2'b00, b[7:6]};
         M_QUAD:  return b[7:4];
         default: return {2'b00, b[7], 1'b0};
      endcase
   endfunction

   function automatic logic [7:0] f_shl(input mode_t m, input logic [7:0] b);
      case (m)
         M_DUAL:  return {b[5:0], 2'b00};
         M_QUAD:  return {b[3:0], 4'b0000};
         default: return {b[6:0], 1'b0};
      endcase
   endfunction

   assign w_rise      = r_clk_s2 & ~r_clk_d;
   assign w_fall      = ~r_clk_s2 & r_clk_d;
   assign w_cmd_byte  = {r_cmd_sr, r_io_s2};
   assign w_addr_rx   = {r_addr_sr, r_io_s2};
   assign w_addr_inc  = r_addr + AW'(1);
   assign w_word      = r_en_d ? romcode_Dout_A : r_word;
   assign w_byte      = w_word[8*r_addr[1:0] +: 8];
   assign w_unused_io = &{1'b0, io_in[3:1]};

   // r_live keeps the reset value of the csb synchroniser from arming a transfer
   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
         r_csb_s1 <= 1'b1;
         r_csb_s2 <= 1'b1;
         r_clk_s1 <= 1'b0;
         r_clk_s2 <= 1'b0;
         r_clk_d  <= 1'b0;
         r_io_s1  <= 1'b0;
         r_io_s2  <= 1'b0;
         r_live   <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_csb_s1 <= csb;
         r_csb_s2 <= r_csb_s1;
         r_clk_s1 <= spiclk;
         r_clk_s2 <= r_clk_s1;
         r_clk_d  <= r_clk_s2;
         r_io_s1  <= io_in[0];
         r_io_s2  <= r_io_s1;
         r_live   <= {r_live[0], 1'b1};
         if (r_live[1] && r_csb_s2) r_armed <= 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_cmd_state = ADDR;
      w_cmd_mode  = M_SINGLE;
      case (w_cmd_byte)
         8'h03, 8'h0B: ;
         8'h3B: w_cmd_mode = M_DUAL;
`ifdef SPIFLASH_QUAD_EN
         8'h6B: w_cmd_mode = M_QUAD;
`endif
         default: w_cmd_state = IGNORE;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_csb_s2) w_state_nxt = IDLE;
      else begin
         case (r_state)
            IDLE:    if (r_armed) w_state_nxt = CMD;
            CMD:     if (w_rise && r_cnt == 8'd7) w_state_nxt = w_cmd_state;
            ADDR:    if (w_rise && r_cnt == ADDR_LAST) w_state_nxt = r_dummy ? DUMMY : DATA;
            DUMMY:   if (w_rise && r_cnt == DUMMY_LAST) w_state_nxt = DATA;
            default: ;
         endcase
      end
   end

   always_comb begin
      io_oe = 4'b0000;
      if (r_state == DATA) begin
         case (r_mode)
            M_DUAL:  io_oe = 4'b0011;
            M_QUAD:  io_oe = 4'b1111;
            default: io_oe = 4'b0010;
         endcase
      end
`ifndef SPIFLASH_QUAD_EN
      io_oe[3:2] = 2'b00;
`endif
      io_out = r_out & io_oe;
   end

   // A new byte is loaded on the fall after its predecessor's last group; lane 3 prefetches
   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
         r_cmd_sr  <= '0;
         r_addr_sr <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_gcnt    <= '0;
         r_sh      <= '0;
         r_out     <= '0;
         r_word    <= '0;
         r_baddr   <= '0;
         r_en      <= 1'b0;
         r_en_d    <= 1'b0;
         r_mode    <= M_SINGLE;
         r_dummy   <= 1'b0;
      end else begin
         r_en   <= 1'b0;
         r_en_d <= r_en;
         if (r_en_d) r_word <= romcode_Dout_A;
         if (r_csb_s2) begin
            r_cmd_sr  <= '0;
            r_addr_sr <= '0;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            r_sh      <= '0;
            r_out     <= '0;
         end else if (w_rise) begin
            case (r_state)
               CMD: begin
                  r_cmd_sr <= w_cmd_byte[6:0];
                  if (r_cnt == 8'd7) begin
                     r_cnt   <= '0;
                     r_mode  <= w_cmd_mode;
                     r_dummy <= (w_cmd_byte != 8'h03) && (DUMMY_CYCLES > 0);
                  end else r_cnt <= r_cnt + 8'd1;
               end
               ADDR: begin
                  r_addr_sr <= w_addr_rx[AW-2:0];
                  if (r_cnt == ADDR_LAST) begin
                     r_cnt   <= '0;
                     r_gcnt  <= '0;
                     r_addr  <= w_addr_rx;
                     r_en    <= 1'b1;
                     r_baddr <= 32'({w_addr_rx[AW-1:2], 2'b00});
                  end else r_cnt <= r_cnt + 8'd1;
               end
               DUMMY:   r_cnt <= r_cnt + 8'd1;
               default: ;
            endcase
         end else if (w_fall && r_state == DATA) begin
            if (r_gcnt == 3'd0) begin
               r_out  <= f_grp(r_mode, w_byte);
               r_sh   <= f_shl(r_mode, w_byte);
               r_gcnt <= (r_mode == M_QUAD) ? 3'd1 : (r_mode == M_DUAL) ? 3'd3 : 3'd7;
               r_addr <= w_addr_inc;
               if (r_addr[1:0] == 2'd3) begin
                  r_en    <= 1'b1;
                  r_baddr <= 32'({w_addr_inc[AW-1:2], 2'b00});
               end
            end else begin
               r_out  <= f_grp(r_mode, r_sh);
               r_sh   <= f_shl(r_mode, r_sh);
               r_gcnt <= r_gcnt - 3'd1;
            end
         end
      end
   end

   assign romcode_Clk_A  = ap_clk;
   assign romcode_Rst_A  = ~ap_rst;
   assign romcode_WEN_A  = '0;
   assign romcode_Din_A  = '0;
   assign romcode_EN_A   = r_en;
   assign romcode_Addr_A = r_baddr;
endmodule

// File: tb/tb_spiflash_mio.sv
// Directed bench for spiflash_mio: SPI mode-0 master tasks plus a behavioural BRAM image.
module tb_spiflash_mio;
   localparam int HALF = 60;

   logic        ap_clk = 1'b0;
   logic        ap_rst, csb, spiclk;
   logic [3:0]  io_in, io_out, io_oe;
   logic [31:0] romcode_Addr_A, romcode_Din_A, romcode_Dout_A;
   logic        romcode_EN_A, romcode_Clk_A, romcode_Rst_A;
   logic [3:0]  romcode_WEN_A;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  rb;
   logic [3:0]  roe;
   logic [7:0]  exp28 [4];

   always #5 ap_clk = ~ap_clk;

   spiflash_mio #(.ADDR_BYTES(3), .DUMMY_CYCLES(8), .MEM_BYTES(8192)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .romcode_Addr_A(romcode_Addr_A), .romcode_EN_A(romcode_EN_A),
      .romcode_WEN_A(romcode_WEN_A), .romcode_Din_A(romcode_Din_A),
      .romcode_Dout_A(romcode_Dout_A), .romcode_Clk_A(romcode_Clk_A),
      .romcode_Rst_A(romcode_Rst_A), .csb(csb), .spiclk(spiclk),
      .io_in(io_in), .io_out(io_out), .io_oe(io_oe)
   );

   // Image: word0 = 44332211, elsewhere byte = a ^ (a >> 8) ^ 5A
   function automatic logic [7:0] img(input int a);
      if (a < 4) return 8'((a + 1) * 17);
      return 8'(a ^ (a >> 8) ^ 'h5A);
   endfunction

   always @(posedge ap_clk) begin
      if (romcode_EN_A) begin
         romcode_Dout_A <= {img(int'(romcode_Addr_A[12:0]) + 3), img(int'(romcode_Addr_A[12:0]) + 2),
                            img(int'(romcode_Addr_A[12:0]) + 1), img(int'(romcode_Addr_A[12:0]))};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      io_in[0] = b;
      #HALF;
      spiclk = 1'b1;
      #HALF;
      spiclk = 1'b0;
   endtask

   task automatic send8(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic xfer_hdr(input logic [7:0] cmd, input logic [23:0] addr, input int ndummy);
      csb = 1'b0;
      #HALF;
      send8(cmd);
      chk("hdr_oe", {28'd0, io_oe}, 32'd0);
      for (int i = 23; i >= 0; i--) send_bit(addr[i]);
      for (int d = 0; d < ndummy; d++) begin
         send_bit(1'b0);
         if (d == 3) chk("dummy_oe", {28'd0, io_oe}, 32'd0);
      end
   endtask

   task automatic read_byte(input int w, output logic [7:0] b, output logic [3:0] oe);
      b  = '0;
      oe = '0;
      for (int k = 0; k < 8 / w; k++) begin
         #HALF;
         oe = io_oe;
         if (w == 1)      b = {b[6:0], io_out[1]};
         else if (w == 2) b = {b[5:0], io_out[1:0]};
         else             b = {b[3:0], io_out};
         spiclk = 1'b1;
         #HALF;
         spiclk = 1'b0;
      end
   endtask

   task automatic end_xfer();
      #HALF;
      csb = 1'b1;
      #(2 * HALF);
   endtask

   initial begin
      ap_rst = 1'b0; csb = 1'b1; spiclk = 1'b0; io_in = '0;
      exp28[0] = 8'h33; exp28[1] = 8'h44; exp28[2] = 8'h5E; exp28[3] = 8'h5F;
      #50;
      chk("rst_oe", {28'd0, io_oe}, 32'd0);
      chk("rst_out", {28'd0, io_out}, 32'd0);
      chk("rst_en", {31'd0, romcode_EN_A}, 32'd0);
      chk("rst_addr", romcode_Addr_A, 32'd0);
      chk("rst_bram_rst", {31'd0, romcode_Rst_A}, 32'd1);
      chk("rst_wen", {28'd0, romcode_WEN_A}, 32'd0);
      chk("rst_din", romcode_Din_A, 32'd0);
      ap_rst = 1'b1;
      #50;
      chk("bram_rst_rel", {31'd0, romcode_Rst_A}, 32'd0);

      xfer_hdr(8'h03, 24'h000000, 0);
      read_byte(1, rb, roe);
      chk("single_b0", {24'd0, rb}, 32'h11);
      chk("single_oe", {28'd0, roe}, 32'h2);
      end_xfer();
      chk("idle_oe", {28'd0, io_oe}, 32'd0);

      xfer_hdr(8'h03, 24'h000020, 0);
      for (int k = 0; k < 20; k++) begin
         read_byte(1, rb, roe);
         chk("burst20", {24'd0, rb}, {24'd0, img(32 + k)});
      end
      end_xfer();

      xfer_hdr(8'h3B, 24'h000002, 8);
      for (int k = 0; k < 4; k++) begin
         read_byte(2, rb, roe);
         chk("dual_byte", {24'd0, rb}, {24'd0, exp28[k]});
         chk("dual_oe", {28'd0, roe}, 32'h3);
      end
      end_xfer();

      xfer_hdr(8'h6B, 24'h001FFF, 8);
`ifdef SPIFLASH_QUAD_EN
      read_byte(4, rb, roe);
      chk("quad_top", {24'd0, rb}, 32'hBA);
      chk("quad_oe", {28'd0, roe}, 32'hF);
      read_byte(4, rb, roe);
      chk("quad_wrap", {24'd0, rb}, 32'h11);
`else
      read_byte(4, rb, roe);
      chk("quad_off_oe", {28'd0, roe}, 32'd0);
      chk("quad_off_out", {24'd0, rb}, 32'd0);
`endif
      end_xfer();

      xfer_hdr(8'h9F, 24'h000000, 0);
      read_byte(1, rb, roe);
      chk("ign_oe", {28'd0, roe}, 32'd0);
      chk("ign_out", {24'd0, rb}, 32'd0);
      end_xfer();
      xfer_hdr(8'h03, 24'h000000, 0);
      read_byte(1, rb, roe);
      chk("after_ign", {24'd0, rb}, 32'h11);
      end_xfer();

      csb = 1'b0;
      #HALF;
      send8(8'h03);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      end_xfer();
      xfer_hdr(8'h03, 24'h000001, 0);
      read_byte(1, rb, roe);
      chk("after_abort", {24'd0, rb}, 32'h22);
      end_xfer();

      xfer_hdr(8'h03, 24'h000000, 0);
      #HALF;
      chk("pre_rst_oe", {28'd0, io_oe}, 32'h2);
      spiclk = 1'b1;
      #20;
      ap_rst = 1'b0;
      #1;
      chk("midrst_oe", {28'd0, io_oe}, 32'd0);
      chk("midrst_out", {28'd0, io_out}, 32'd0);
      #9;
      #20;
      ap_rst = 1'b1;
      spiclk = 1'b0;
      xfer_hdr(8'h03, 24'h000000, 0);
      read_byte(1, rb, roe);
      chk("norearm_oe", {28'd0, roe}, 32'd0);
      end_xfer();
      xfer_hdr(8'h03, 24'h000003, 0);
      read_byte(1, rb, roe);
      chk("rearm_b3", {24'd0, rb}, 32'h44);
      end_xfer();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
